// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer with an IF/ID register. A branch resolved in decode
// while fetch cannot advance is parked and applied on the next advancing cycle.
module pc_fetch_ctrl #(
   parameter int              PC_W     = 7,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            PCSrcD,
   input  logic [PC_W-1:0] PCBranchD,
   input  logic            imem_ready,
   input  logic            halt_req,
   output logic [PC_W-1:0] PCF,
   output logic [PC_W-1:0] PC_Plus1F,
   output logic [PC_W-1:0] PC_Plus1D,
   output logic            ValidD,
   output logic [1:0]      fetch_state,
   output logic [15:0]     fetch_count
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2,
      BAD   = 2'd3
   } state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pcf;
   logic [PC_W-1:0] r_pc_plus1d;
   logic            r_valid_d;
   logic [15:0]     r_count;
   logic            r_redir_pend;
   logic [PC_W-1:0] r_redir_tgt;

   logic            w_in_fetch;
   logic            w_br;
   logic            w_adv;
   logic            w_load_vd;
   logic [PC_W-1:0] w_pc_plus1;

   always_comb begin
      w_in_fetch = (r_state == FETCH);
      w_br       = w_in_fetch & PCSrcD & ~StallD;
      w_adv      = w_in_fetch & imem_ready & ~StallF;
      w_pc_plus1 = r_pcf + PC_W'(1);
      // Words fetched before a parked redirect lands are wrong-path.
      w_load_vd  = ~StallD & ~w_br & w_adv & ~r_redir_pend;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= BOOT;
         r_pcf        <= RESET_PC;
         r_pc_plus1d  <= '0;
         r_valid_d    <= 1'b0;
         r_count      <= '0;
         r_redir_pend <= 1'b0;
         r_redir_tgt  <= '0;
      end else begin
         case (r_state)
            BOOT:    r_state <= FETCH;
            FETCH:   if (halt_req) r_state <= HALT;
            HALT:    r_state <= HALT;
            default: r_state <= BOOT;
         endcase

         if (w_br) begin
            if (w_adv) begin
               r_pcf        <= PCBranchD;
               r_redir_pend <= 1'b0;
            end else begin
               r_redir_pend <= 1'b1;
               r_redir_tgt  <= PCBranchD;
            end
         end else if (w_adv) begin
            if (r_redir_pend) begin
               r_pcf        <= r_redir_tgt;
               r_redir_pend <= 1'b0;
            end else begin
               r_pcf <= w_pc_plus1;
            end
         end

         if (!StallD) begin
            r_valid_d <= w_load_vd;
            if (w_load_vd) r_pc_plus1d <= w_pc_plus1;
         end

         if (w_load_vd && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
   end

   assign PCF         = r_pcf;
   assign PC_Plus1F   = w_pc_plus1;
   assign PC_Plus1D   = r_pc_plus1d;
   assign ValidD      = r_valid_d;
   assign fetch_state = r_state;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vectors for pc_fetch_ctrl; each driven cycle queues its expected
// post-edge outputs, which a free-running monitor pops and compares.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0;
   logic [6:0]  PCBranchD = '0;
   logic        imem_ready = 1'b0, halt_req = 1'b0;
   logic [6:0]  PCF, PC_Plus1F, PC_Plus1D;
   logic        ValidD;
   logic [1:0]  fetch_state;
   logic [15:0] fetch_count;

   typedef struct {
      logic [6:0]  pcf;
      logic [6:0]  p1d;
      logic        vd;
      logic [1:0]  st;
      logic [15:0] cnt;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   pc_fetch_ctrl #(.PC_W(7), .RESET_PC(7'd0)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD),
      .PCBranchD(PCBranchD), .imem_ready(imem_ready), .halt_req(halt_req),
      .PCF(PCF), .PC_Plus1F(PC_Plus1F), .PC_Plus1D(PC_Plus1D), .ValidD(ValidD),
      .fetch_state(fetch_state), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue what the outputs must be after the edge.
   task automatic cyc(input logic r, input logic sf, input logic sd, input logic br,
                      input logic [6:0] tgt, input logic ir, input logic hr,
                      input logic [6:0] e_pcf, input logic [6:0] e_p1d, input logic e_vd,
                      input logic [1:0] e_st, input logic [15:0] e_cnt, input string nm);
      exp_t e;
      @(negedge clk);
      rst = r; StallF = sf; StallD = sd; PCSrcD = br; PCBranchD = tgt;
      imem_ready = ir; halt_req = hr;
      e.pcf = e_pcf; e.p1d = e_p1d; e.vd = e_vd; e.st = e_st; e.cnt = e_cnt; e.nm = nm;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [6:0] e_p1f;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            e_p1f = e.pcf + 7'd1;
            n_tot++;
            if (PCF === e.pcf && PC_Plus1F === e_p1f && PC_Plus1D === e.p1d &&
                ValidD === e.vd && fetch_state === e.st && fetch_count === e.cnt)
               n_pass++;
            else
               $display("FAIL %s: got PCF=%0d P1F=%0d P1D=%0d VD=%b st=%0d cnt=%0d, want PCF=%0d P1F=%0d P1D=%0d VD=%b st=%0d cnt=%0d",
                        e.nm, PCF, PC_Plus1F, PC_Plus1D, ValidD, fetch_state, fetch_count,
                        e.pcf, e_p1f, e.p1d, e.vd, e.st, e.cnt);
         end
      end
   end

   initial begin : stim
      int wait_cyc;
      //   rst sf sd br tgt    ir hr   pcf    p1d   vd st cnt
      cyc(1, 0, 0, 0, 7'd0,   0, 0,  7'd0,  7'd0, 0, 0, 0,  "reset");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd0,  7'd0, 0, 1, 0,  "boot");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd1,  7'd1, 1, 1, 1,  "fetch1");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd2,  7'd2, 1, 1, 2,  "fetch2");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd3,  7'd3, 1, 1, 3,  "fetch3");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd4,  7'd4, 1, 1, 4,  "fetch4");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd5,  7'd5, 1, 1, 5,  "fetch5");
      cyc(0, 0, 0, 1, 7'd40,  1, 0,  7'd40, 7'd5, 0, 1, 5,  "br_adv");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd41, 7'd41,1, 1, 6,  "after_br");
      cyc(0, 0, 0, 1, 7'd9,   1, 0,  7'd9,  7'd41,0, 1, 6,  "br_to9");
      cyc(0, 0, 0, 1, 7'd20,  0, 0,  7'd9,  7'd41,0, 1, 6,  "br_noadv");
      cyc(0, 0, 0, 0, 7'd0,   0, 0,  7'd9,  7'd41,0, 1, 6,  "pend_hold");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd20, 7'd41,0, 1, 6,  "redir_apply");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd21, 7'd21,1, 1, 7,  "after_redir");
      cyc(0, 0, 0, 1, 7'd50,  0, 0,  7'd21, 7'd21,0, 1, 7,  "pend_50");
      cyc(0, 0, 0, 1, 7'd60,  0, 0,  7'd21, 7'd21,0, 1, 7,  "pend_overwrite");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd60, 7'd21,0, 1, 7,  "redir_60");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd61, 7'd61,1, 1, 8,  "after_60");
      cyc(0, 1, 1, 1, 7'd100, 1, 0,  7'd61, 7'd61,1, 1, 8,  "stall_br_ign");
      cyc(0, 1, 0, 0, 7'd0,   1, 0,  7'd61, 7'd61,0, 1, 8,  "stallF_bubble");
      cyc(0, 0, 1, 0, 7'd0,   1, 0,  7'd62, 7'd61,0, 1, 8,  "stallD_hold");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd63, 7'd63,1, 1, 9,  "resume");
      cyc(0, 0, 0, 1, 7'd127, 1, 0,  7'd127,7'd63,0, 1, 9,  "br_127");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd0,  7'd0, 1, 1, 10, "wrap");
      cyc(0, 0, 0, 1, 7'd12,  1, 0,  7'd12, 7'd0, 0, 1, 10, "br_12");
      cyc(0, 0, 0, 0, 7'd0,   1, 1,  7'd13, 7'd13,1, 2, 11, "halt");
      cyc(0, 0, 0, 1, 7'd77,  1, 0,  7'd13, 7'd13,0, 2, 11, "halt_br_ign");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd13, 7'd13,0, 2, 11, "halt_frozen");
      cyc(1, 0, 0, 1, 7'd5,   1, 0,  7'd0,  7'd0, 0, 0, 0,  "reset_halt");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd0,  7'd0, 0, 1, 0,  "reboot");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd1,  7'd1, 1, 1, 1,  "refetch");
      cyc(0, 0, 0, 1, 7'd30,  0, 0,  7'd1,  7'd1, 0, 1, 1,  "pend_30");
      cyc(1, 1, 1, 0, 7'd0,   1, 0,  7'd0,  7'd0, 0, 0, 0,  "reset_pend");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd0,  7'd0, 0, 1, 0,  "reboot2");
      cyc(0, 0, 0, 0, 7'd0,   1, 0,  7'd1,  7'd1, 1, 1, 1,  "pend_cleared");
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_tot++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
